lms_train_ctrl: RTL

Training sequencer for the 3-tap LMS adaptive FIR. It clears the filter, enables coefficient adaptation, and measures mean absolute error over fixed sample windows. It declares convergence after a run of good windows and then freezes the coefficients, or declares failure after a window budget is spent. It sits between the system control bus and the adaptive filter, driving the filter's reset and adaptation-enable inputs.

---
 rtl/lms_train_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/lms_train_ctrl.sv
// Training sequencer for the 3-tap LMS adaptive FIR: flush, adapt, window mean-|e| monitor, freeze or give up.
// Optional macro LMS_CTRL_RETRAIN_EN: a frozen filter whose window error reaches 2*threshold is retrained.
module lms_train_ctrl #(
  parameter int NB_DATA   = 16,
  parameter int LOG2_WIN  = 6,
  parameter int CONV_WIN  = 4,
  parameter int MAX_WIN   = 255,
  parameter int FLUSH_CYC = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic               i_sample_valid,
  input  logic [NB_DATA-1:0] i_err,
  input  logic [NB_DATA-2:0] i_thr,
  output logic               o_fir_rst,
  output logic               o_adapt_en,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_fail,
  output logic [NB_DATA-2:0] o_mae,
  output logic               o_mae_valid
);

  localparam int ACC_W = NB_DATA - 1 + LOG2_WIN;
  localparam int FC_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_CYC - 1);
  localparam logic [3:0]      CONV_TGT   = 4'(CONV_WIN);
  localparam logic [7:0]      MAX_TGT    = 8'(MAX_WIN);

  typedef enum logic [2:0] {IDLE, FLUSH, TRAIN, FROZEN, FAIL} state_t;

  state_t state, next_state;

  logic [FC_W-1:0]     flush_cnt;
  logic [ACC_W-1:0]    acc;
  logic [LOG2_WIN-1:0] sample_cnt;
  logic [7:0]          win_cnt;
  logic [3:0]          run_cnt;

  logic [NB_DATA-1:0]  neg_err;
  logic [NB_DATA-2:0]  abs_err;
  logic [ACC_W-1:0]    acc_sum;
  logic [NB_DATA-2:0]  mae_new;
  logic                measuring, win_close, good, retrain;
  logic [3:0]          run_next;
  logic [7:0]          win_next;

  logic                fir_rst_d, adapt_d, busy_d, done_d, fail_d, mae_valid_d;
  logic [NB_DATA-2:0]  mae_d;

  // Window datapath; the most negative error has no positive twin and saturates.
  always_comb begin
    neg_err = -i_err;
    abs_err = i_err[NB_DATA-2:0];
    if (i_err[NB_DATA-1])
      abs_err = neg_err[NB_DATA-1] ? '1 : neg_err[NB_DATA-2:0];
    acc_sum   = acc + ACC_W'(abs_err);
    measuring = ((state == TRAIN) || (state == FROZEN)) && i_sample_valid && !i_start && !i_abort;
    win_close = measuring && (sample_cnt == '1);
    mae_new   = acc_sum[ACC_W-1:LOG2_WIN];
    good      = mae_new < i_thr;
    run_next  = good ? ((run_cnt == CONV_TGT) ? run_cnt : run_cnt + 1'b1) : '0;
    win_next  = (win_cnt == MAX_TGT) ? win_cnt : win_cnt + 1'b1;
`ifdef LMS_CTRL_RETRAIN_EN
    retrain   = {1'b0, mae_new} >= {i_thr, 1'b0};
`else
    retrain   = 1'b0;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= next_state;
  end

  // Abort beats start, start beats everything else.
  always_comb begin
    next_state = state;
    if (i_abort)
      next_state = IDLE;
    else if (i_start)
      next_state = FLUSH;
    else begin
      case (state)
        IDLE:   next_state = IDLE;
        FLUSH:  if (flush_cnt == FLUSH_LAST) next_state = TRAIN;
        TRAIN:  if (win_close) begin
                  if (run_next == CONV_TGT)     next_state = FROZEN;
                  else if (win_next == MAX_TGT) next_state = FAIL;
                end
        FROZEN: if (win_close && retrain) next_state = FLUSH;
        FAIL:   next_state = FAIL;
        default: next_state = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered copies line up with the state.
  always_comb begin
    fir_rst_d   = (next_state == FLUSH);
    adapt_d     = (next_state == TRAIN);
    busy_d      = (next_state == FLUSH) || (next_state == TRAIN);
    done_d      = (next_state == FROZEN);
    fail_d      = (next_state == FAIL);
    mae_valid_d = win_close;
    mae_d       = o_mae;
    if (next_state == IDLE) mae_d = '0;
    else if (win_close)     mae_d = mae_new;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_fir_rst   <= 1'b0;
      o_adapt_en  <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_fail      <= 1'b0;
      o_mae       <= '0;
      o_mae_valid <= 1'b0;
    end else begin
      o_fir_rst   <= fir_rst_d;
      o_adapt_en  <= adapt_d;
      o_busy      <= busy_d;
      o_done      <= done_d;
      o_fail      <= fail_d;
      o_mae       <= mae_d;
      o_mae_valid <= mae_valid_d;
    end
  end

  // A restart inside FLUSH rewinds the flush timer; the closing strobe's sum restarts the window at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      flush_cnt  <= '0;
      acc        <= '0;
      sample_cnt <= '0;
      win_cnt    <= '0;
      run_cnt    <= '0;
    end else begin
      flush_cnt <= ((state == FLUSH) && (next_state == FLUSH) && !i_start) ? flush_cnt + 1'b1 : '0;
      if (state == FLUSH) begin
        acc        <= '0;
        sample_cnt <= '0;
        win_cnt    <= '0;
        run_cnt    <= '0;
      end else if (measuring) begin
        if (win_close) begin
          acc        <= '0;
          sample_cnt <= '0;
          win_cnt    <= win_next;
          run_cnt    <= run_next;
        end else begin
          acc        <= acc_sum;
          sample_cnt <= sample_cnt + 1'b1;
        end
      end
    end
  end

endmodule
